reg_write_scheduler: RTL

REG_WRITE_SCHEDULER -- requirements
Module: reg_write_scheduler

---
 rtl/reg_write_scheduler.sv | 86 ++++++++
 1 files changed

// File: rtl/reg_write_scheduler.sv
// Four-requester register write scheduler: round-robin grant, one-cycle write
// strobe with matching ack, then a four-phase release before the next grant.
module reg_write_scheduler #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        req,
    input  logic [DATA_W-1:0] data0,
    input  logic [DATA_W-1:0] data1,
    input  logic [DATA_W-1:0] data2,
    input  logic [DATA_W-1:0] data3,
    output logic [3:0]        wr_en,
    output logic [DATA_W-1:0] wr_data,
    output logic [3:0]        ack,
    output logic [1:0]        grant_idx,
    output logic              busy
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] WRITE   = 2'd1;
    localparam logic [1:0] RELEASE = 2'd2;

    logic [1:0]              state;
    logic [1:0]              ptr;
    logic [1:0]              pick;
    logic [1:0]              idx;
    logic                    found;
    logic [3:0][DATA_W-1:0]  data;

    assign data = {data3, data2, data1, data0};
    assign busy = (state != IDLE);

    // Scan from the farthest offset down so the index nearest ptr wins.
    always_comb begin
        pick  = ptr;
        idx   = ptr;
        found = 1'b0;
        for (int k = 3; k >= 0; k--) begin
            idx = ptr + 2'(k);
            if (req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= 2'd0;
            wr_en     <= 4'b0;
            ack       <= 4'b0;
            wr_data   <= '0;
            grant_idx <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        state     <= WRITE;
                        wr_en     <= 4'b1 << pick;
                        ack       <= 4'b1 << pick;
                        wr_data   <= data[pick];
                        grant_idx <= pick;
                        ptr       <= pick + 2'd1;
                    end
                end
                WRITE: begin
                    state <= RELEASE;
                    wr_en <= 4'b0;
                    ack   <= 4'b0;
                end
                RELEASE: begin
                    // Hold off new grants until the winner drops its request.
                    if (!req[grant_idx]) state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    wr_en <= 4'b0;
                    ack   <= 4'b0;
                end
            endcase
        end
    end

endmodule
